// File: rtl/dmac_wrr_pkt_arbiter.sv
// Weighted round-robin packet arbiter: shares one DMAC destination stream
// among N_MASTER source channels, granting whole packets, up to weight_i[m]
// packets per grant.
// Optional feature macro: DMAC_ARB_STATS_EN adds per-channel packet counters
// on pkt_cnt_o.
module dmac_wrr_pkt_arbiter #(
  parameter int unsigned N_MASTER  = 4,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned WEIGHT_W  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_MASTER-1:0][WEIGHT_W-1:0]   weight_i,
  input  logic [N_MASTER-1:0]                 src_valid_i,
  output logic [N_MASTER-1:0]                 src_ready_o,
  input  logic [N_MASTER-1:0][DATA_SIZE-1:0]  src_data_i,
  input  logic [N_MASTER-1:0]                 src_last_i,
  output logic                                dst_valid_o,
  input  logic                                dst_ready_i,
  output logic [DATA_SIZE-1:0]                dst_data_o,
  output logic                                dst_last_o,
  output logic [N_MASTER-1:0]                 grant_o,
  output logic                                busy_o
`ifdef DMAC_ARB_STATS_EN
  ,
  output logic [N_MASTER-1:0][15:0]           pkt_cnt_o
`endif
);

  localparam int unsigned IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e              state_q, state_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                in_pkt_q, in_pkt_d;
  logic                rel;
  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;

  // First eligible channel searching upward from rr_ptr with wrap-around
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % N_MASTER);
      if (!win_vld && src_valid_i[cand] && (weight_i[cand] != '0)) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state logic and granted-channel data path
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    in_pkt_d    = in_pkt_q;
    rel         = 1'b0;
    src_ready_o = '0;
    dst_valid_o = 1'b0;
    dst_data_o  = '0;
    dst_last_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d  = S_GRANT;
          grant_d  = N_MASTER'(1) << win_idx;
          gidx_d   = win_idx;
          credit_d = weight_i[win_idx];
          in_pkt_d = 1'b0;
        end
      end
      S_GRANT: begin
        // Outputs held quiet while reset is asserted so nothing transfers
        if (rst_n) begin
          dst_valid_o         = src_valid_i[gidx_q];
          dst_data_o          = src_data_i[gidx_q];
          dst_last_o          = src_last_i[gidx_q];
          src_ready_o[gidx_q] = dst_ready_i;
        end
        if (src_valid_i[gidx_q] && dst_ready_i) begin
          if (src_last_i[gidx_q]) begin
            in_pkt_d = 1'b0;
            if (credit_q > WEIGHT_W'(1)) begin
              credit_d = credit_q - WEIGHT_W'(1);
            end else begin
              credit_d = '0;
              rel      = 1'b1;
            end
          end else begin
            in_pkt_d = 1'b1;
          end
        end else if (!in_pkt_q && !src_valid_i[gidx_q]) begin
          rel = 1'b1;
        end
        if (rel) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx_q == IDX_W'(N_MASTER - 1)) ? '0 : gidx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and grant registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      credit_q <= '0;
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == S_GRANT);

`ifdef DMAC_ARB_STATS_EN
  logic [N_MASTER-1:0][15:0] pkt_cnt_q;
  logic                      last_hs;

  assign last_hs = dst_valid_o & dst_ready_i & dst_last_o;

  // Completed-packet counters per channel, free-running with wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (last_hs) begin
      pkt_cnt_q[gidx_q] <= pkt_cnt_q[gidx_q] + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule
